// File: rtl/adxl345_spi_pkg.sv
// Shared types and constants for the ADXL345 SPI master.
// Holds the FSM state encoding, register map constants and field widths.
package adxl345_spi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [5:0] DEVID       = 6'h00;
    localparam logic [5:0] POWER_CTL   = 6'h2D;
    localparam logic [5:0] DATA_FORMAT = 6'h31;
    localparam logic [5:0] DATAX0      = 6'h32;

    localparam logic [7:0] DEVID_VALUE = 8'hE5;

    localparam int CMD_W  = 8;
    localparam int DATA_W = 8;

endpackage

// File: rtl/adxl345_spi_master_if.sv
// Request/response bus between a host and the ADXL345 SPI master.
// master: start, rw, burst, addr, wdata out; busy, done, rdata, rdata_valid in.
interface adxl345_spi_master_if;
    import adxl345_spi_pkg::*;

    logic              start;
    logic              rw;
    logic              burst;
    logic [5:0]        addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;

    modport master (
        output start, rw, burst, addr, wdata,
        input  busy, done, rdata, rdata_valid
    );

    modport slave (
        input  start, rw, burst, addr, wdata,
        output busy, done, rdata, rdata_valid
    );

endinterface

// File: rtl/clk_edge_detect.sv
// Synchronises clk_32 into the clk domain and emits 1-cycle rise/fall ticks.
// Ports: clk, reset_n, clk_32 in; rise_tick, fall_tick out.
module clk_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_32,
    output logic rise_tick,
    output logic fall_tick
);

    logic s1_q, s2_q, d_q;

    // Reset to 1 so that a high clk_32 at reset release gives no tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            d_q  <= 1'b1;
        end else begin
            s1_q <= clk_32;
            s2_q <= s1_q;
            d_q  <= s2_q;
        end
    end

    assign rise_tick = s2_q & ~d_q;
    assign fall_tick = ~s2_q & d_q;

endmodule

// File: rtl/adxl345_spi_master.sv
// SPI mode-3 master for the ADXL345; one register transaction per start.
// Ports: clk, reset_n, clk_32, bus (slave modport), sclk, cs_n, mosi out, miso in.
// Macro ADXL_BURST_EN enables multi-byte burst reads (MB=1).
module adxl345_spi_master
    import adxl345_spi_pkg::*;
#(
    parameter int BURST_BYTES = 6,
    parameter int GAP_TICKS   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_32,
    adxl345_spi_master_if.slave   bus,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int XFER_W = CMD_W + DATA_W;

`ifdef ADXL_BURST_EN
    localparam int CNT_W = $clog2(CMD_W + DATA_W * BURST_BYTES);
    localparam logic [CNT_W-1:0] LAST_BRST =
        CNT_W'(CMD_W + DATA_W * BURST_BYTES - 1);
`else
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BRST = CNT_W'(XFER_W - 1);
    localparam int unused_burst_bytes = BURST_BYTES;
`endif

    localparam logic [CNT_W-1:0] LAST_STD = CNT_W'(XFER_W - 1);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    logic rise_tick, fall_tick;
    logic mb_in;

    state_t              state_q, state_n;
    logic [XFER_W-1:0]   shift_q, shift_n;
    logic [DATA_W-2:0]   rx_q, rx_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [GW-1:0]       gap_q, gap_n;
    logic                rd_q, rd_n;
    logic                brst_q, brst_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic [DATA_W-1:0]   rdata_q, rdata_n;
    logic                rv_q, rv_n;
    logic                sclk_q, sclk_n;
    logic                cs_q, cs_n_n;
    logic                mosi_q, mosi_n;
    logic [CNT_W-1:0]    last_bit;

    clk_edge_detect u_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_32    (clk_32),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

`ifdef ADXL_BURST_EN
    assign mb_in = bus.rw & bus.burst;
`else
    logic unused_burst;
    assign unused_burst = bus.burst;
    assign mb_in = 1'b0;
`endif

    assign last_bit = brst_q ? LAST_BRST : LAST_STD;

    always_comb begin
        state_n = state_q;
        shift_n = shift_q;
        rx_n    = rx_q;
        cnt_n   = cnt_q;
        gap_n   = gap_q;
        rd_n    = rd_q;
        brst_n  = brst_q;
        busy_n  = busy_q;
        done_n  = 1'b0;
        rdata_n = rdata_q;
        rv_n    = 1'b0;
        sclk_n  = sclk_q;
        cs_n_n  = cs_q;
        mosi_n  = mosi_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Reads shift zeros after the command byte.
                    shift_n = {bus.rw, mb_in, bus.addr,
                               bus.rw ? '0 : bus.wdata};
                    rd_n    = bus.rw;
                    brst_n  = mb_in;
                    cs_n_n  = 1'b0;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = S_SETUP;
                end
            end
            S_SETUP: begin
                if (fall_tick) state_n = S_SHIFT;
            end
            S_SHIFT: begin
                if (fall_tick) begin
                    sclk_n  = 1'b0;
                    mosi_n  = shift_q[XFER_W-1];
                    shift_n = {shift_q[XFER_W-2:0], 1'b0};
                end else if (rise_tick && !sclk_q) begin
                    // Only a rise after a driven fall completes a bit.
                    sclk_n = 1'b1;
                    rx_n   = {rx_q[DATA_W-3:0], miso};
                    cnt_n  = cnt_q + CNT_W'(1);
                    if (rd_q && cnt_q[2:0] == 3'b111 &&
                        cnt_q >= LAST_STD) begin
                        rdata_n = {rx_q, miso};
                        rv_n    = 1'b1;
                    end
                    if (cnt_q == last_bit) state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                if (fall_tick) begin
                    cs_n_n  = 1'b1;
                    mosi_n  = 1'b0;
                    gap_n   = '0;
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (rise_tick || fall_tick) begin
                    if (gap_q == GAP_LAST) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        state_n = S_IDLE;
                    end else begin
                        gap_n = gap_q + GW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            rd_q    <= 1'b0;
            brst_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            rv_q    <= 1'b0;
            sclk_q  <= 1'b1;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            shift_q <= shift_n;
            rx_q    <= rx_n;
            cnt_q   <= cnt_n;
            gap_q   <= gap_n;
            rd_q    <= rd_n;
            brst_q  <= brst_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            rdata_q <= rdata_n;
            rv_q    <= rv_n;
            sclk_q  <= sclk_n;
            cs_q    <= cs_n_n;
            mosi_q  <= mosi_n;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rv_q;
    assign sclk            = sclk_q;
    assign cs_n            = cs_q;
    assign mosi            = mosi_q;

endmodule
